tlight_seq: RTL

TLIGHT_SEQ -- requirements
Module: tlight_seq

---
 rtl/tlight_pkg.sv | 31 +++
 rtl/tlight_frame_cnt.sv | 31 +++
 rtl/tlight_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/tlight_pkg.sv
// Shared definitions for the traffic-light sequencer and the tlight display colour mux.
package tlight_pkg;

   typedef enum logic [2:0] {
      RED,
      WALK,
      GRN,
      YEL,
      FLASH_ON,
      FLASH_OFF
   } tl_state_t;

   localparam logic [1:0] COLOR_RED = 2'd0;
   localparam logic [1:0] COLOR_YEL = 2'd1;
   localparam logic [1:0] COLOR_GRN = 2'd2;
   localparam logic [1:0] COLOR_OFF = 2'd3;

   function automatic logic [1:0] state_color(input tl_state_t s);
      case (s)
         RED, WALK:     return COLOR_RED;
         GRN:           return COLOR_GRN;
         YEL, FLASH_ON: return COLOR_YEL;
         default:       return COLOR_OFF;
      endcase
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/tlight_frame_cnt.sv
// Per-phase frame counter: clears on phase entry, counts frame ticks, flags expiry.
module tlight_frame_cnt #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         tick,
   input  logic [W-1:0] dur,
   output logic         done
);

   logic [W-1:0] r_cnt;
   logic         w_last;

   // >= rather than == so a duration shortened below the running count
   // (early green exit) expires at once; the counter still never wraps.
   assign w_last = (r_cnt >= dur - W'(1));
   assign done   = tick & w_last;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (tick && !w_last) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

endmodule

// File: rtl/tlight_seq.sv
// Frame-paced traffic-light sequencer with pedestrian walk phase and flashing-yellow mode.
module tlight_seq #(
   parameter int unsigned RED_FRAMES     = 240,
   parameter int unsigned GRN_FRAMES     = 240,
   parameter int unsigned YEL_FRAMES     = 120,
   parameter int unsigned WALK_FRAMES    = 180,
   parameter int unsigned GRN_MIN_FRAMES = 60,
   parameter int unsigned FLASH_FRAMES   = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       enable,
   input  logic       ped_req,
   output logic [1:0] color_sel,
   output logic       walk,
   output logic       phase_start
);

   import tlight_pkg::*;

   localparam int unsigned MAX_DUR = max_u(max_u(max_u(RED_FRAMES, GRN_FRAMES),
                                                 max_u(YEL_FRAMES, WALK_FRAMES)),
                                           FLASH_FRAMES);
   localparam int unsigned CW = $clog2(MAX_DUR + 1);

   if (RED_FRAMES < 1 || GRN_FRAMES < 1 || YEL_FRAMES < 1 || WALK_FRAMES < 1 ||
       GRN_MIN_FRAMES < 1 || FLASH_FRAMES < 1 || GRN_MIN_FRAMES > GRN_FRAMES) begin : g_bad_params
      $error("tlight_seq: frame durations must be >= 1 and GRN_MIN_FRAMES <= GRN_FRAMES");
   end

   tl_state_t   r_state;
   tl_state_t   w_next;
   logic        r_ped_pend;
   logic [1:0]  r_color;
   logic        r_walk;
   logic        r_phase;
   logic        w_done;
   logic        w_change;
   logic        w_normal;
   logic [CW-1:0] w_dur;

   assign w_normal = !(r_state inside {FLASH_ON, FLASH_OFF});
   assign w_change = (w_next != r_state);

   // A pending request shortens green to its minimum; the counter expires on it.
   always_comb begin
      w_dur = CW'(FLASH_FRAMES);
      case (r_state)
         RED:     w_dur = CW'(RED_FRAMES);
         WALK:    w_dur = CW'(WALK_FRAMES);
         GRN:     w_dur = r_ped_pend ? CW'(GRN_MIN_FRAMES) : CW'(GRN_FRAMES);
         YEL:     w_dur = CW'(YEL_FRAMES);
         default: w_dur = CW'(FLASH_FRAMES);
      endcase
   end

   tlight_frame_cnt #(.W(CW)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (w_change),
      .tick  (frame_tick),
      .dur   (w_dur),
      .done  (w_done)
   );

   always_comb begin
      w_next = r_state;
      if (frame_tick) begin
         if (w_normal && !enable) begin
            w_next = FLASH_ON;
         end else begin
            case (r_state)
               RED:       if (w_done) w_next = r_ped_pend ? WALK : GRN;
               WALK:      if (w_done) w_next = GRN;
               GRN:       if (w_done) w_next = YEL;
               YEL:       if (w_done) w_next = RED;
               FLASH_ON:  if (enable) w_next = RED; else if (w_done) w_next = FLASH_OFF;
               FLASH_OFF: if (enable) w_next = RED; else if (w_done) w_next = FLASH_ON;
               default:   w_next = RED;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ped_pend <= 1'b0;
      end else if (!w_normal || r_state == WALK || w_next == WALK) begin
         r_ped_pend <= 1'b0;
      end else if (ped_req) begin
         r_ped_pend <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= RED;
         r_color <= COLOR_RED;
         r_walk  <= 1'b0;
         r_phase <= 1'b0;
      end else begin
         r_state <= w_next;
         r_color <= state_color(w_next);
         r_walk  <= (w_next == WALK);
         r_phase <= w_change;
      end
   end

   assign color_sel   = r_color;
   assign walk        = r_walk;
   assign phase_start = r_phase;

endmodule
